// File: rtl/reg_file_pkg.sv
// Shared definitions for the 16-bit register file and its initiator.
//   DATA_W, ADDR_W, NUM_REGS : geometry shared with `top` and the scoreboard
//   op_e                     : command opcode encoding on the command channel
//   state_t / St*            : initiator FSM state encoding
package reg_file_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 14;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StWr      = 3'd1;
    localparam state_t StRdIssue = 3'd2;
    localparam state_t StRdWait  = 3'd3;
    localparam state_t StFill    = 3'd4;
    localparam state_t StResp    = 3'd5;

endpackage

// File: rtl/reg_file_master.sv
// Initiator for the register file: takes one READ/WRITE/FILL command at a time on a
// valid/ready channel, strobes the register file, and returns one response per command.
//   clk, rst                      : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_ready           : response handshake; rsp_data/rsp_err payload
//   busy                          : high whenever the FSM is not idle
//   reg_write_en/reg_read_en      : register-file strobes (never both high)
//   reg_addr/reg_data_in          : register-file address and write data
//   reg_data_out                  : register-file read data, valid RD_LAT cycles after read
module reg_file_master
    import reg_file_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              reg_write_en,
    output logic              reg_read_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out
);

    localparam int unsigned       CntW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0]   LastCnt    = CntW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NumRegsExt = (ADDR_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic                init_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                accept;
    logic                bad_addr;

    // init_q keeps cmd_ready low until the first clock after reset release.
    assign cmd_ready = (state_q == StIdle) && init_q;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_addr  = {1'b0, cmd_addr} >= NumRegsExt;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    rsp_data_d = cmd_data;
                    rsp_err_d  = 1'b0;
                    case (op_e'(cmd_op))
                        OP_READ:  state_d = bad_addr ? StResp : StRdIssue;
                        OP_WRITE: state_d = bad_addr ? StResp : StWr;
                        OP_FILL: begin
                            idx_d   = '0;
                            state_d = StFill;
                        end
                        default:  state_d = StResp;
                    endcase
                    // Rejected commands answer straight away with zero data.
                    if ((op_e'(cmd_op) == OP_RSVD) ||
                        ((op_e'(cmd_op) != OP_FILL) && bad_addr)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end
            StWr:      state_d = StResp;
            StRdIssue: begin
                cnt_d   = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (cnt_q == LastCnt) begin
                    rsp_data_d = reg_data_out;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFill: begin
                if (idx_q == LastIdx) begin
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            init_q     <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= 1'b1;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode from state alone so a reset drops them without waiting for a clock.
    always_comb begin
        reg_write_en = 1'b0;
        reg_read_en  = 1'b0;
        reg_addr     = '0;
        reg_data_in  = '0;
        case (state_q)
            StWr: begin
                reg_write_en = 1'b1;
                reg_addr     = addr_q;
                reg_data_in  = data_q;
            end
            StRdIssue: begin
                reg_read_en = 1'b1;
                reg_addr    = addr_q;
            end
            StRdWait:  reg_addr = addr_q;
            StFill: begin
                reg_write_en = 1'b1;
                reg_addr     = idx_q;
                reg_data_in  = data_q;
            end
            default: ;
        endcase
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_valid ? rsp_data_q : '0;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_reg_file_master.sv
// Self-checking bench for reg_file_master. A behavioural register file answers the
// strobes; an array-based reference model predicts every response and strobe count.
module tb_reg_file_master;
    import reg_file_pkg::*;

    localparam int unsigned RdLat = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              reg_write_en;
    logic              reg_read_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data_in;
    logic [DATA_W-1:0] reg_data_out;

    reg_file_master #(.RD_LAT(RdLat)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_addr     (reg_addr),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural register file with one cycle of read latency.
    logic [DATA_W-1:0] file_mem [16];
    always @(posedge clk) begin
        if (reg_write_en) file_mem[reg_addr] <= reg_data_in;
        if (reg_read_en)  reg_data_out <= file_mem[reg_addr];
    end

    // Strobe monitor, sampled mid-cycle.
    int wr_total = 0;
    int rd_total = 0;
    int both_hits = 0;
    int wr_hits [16];
    always @(negedge clk) begin
        if (reg_write_en === 1'b1) begin
            wr_total++;
            wr_hits[reg_addr]++;
        end
        if (reg_read_en === 1'b1) rd_total++;
        if (reg_write_en === 1'b1 && reg_read_en === 1'b1) both_hits++;
    end

    int total = 0;
    int bad = 0;
    logic [DATA_W-1:0] model_regs [NUM_REGS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] addr,
                        input logic [15:0] data, input int hold, input string tag);
        logic        exp_err;
        logic [15:0] exp_data;
        int          exp_edges, exp_wr, exp_rd;
        int          wr0, rd0, edges;
        int          hits0 [16];
        logic [15:0] held;
        logic [15:0] mask;

        exp_err  = (op == 2'b11) || (op != 2'b10 && int'(addr) >= int'(NUM_REGS));
        exp_data = exp_err ? 16'h0 : (op == 2'b00) ? model_regs[addr] : data;
        exp_wr   = exp_err ? 0 : (op == 2'b01) ? 1 : (op == 2'b10) ? int'(NUM_REGS) : 0;
        exp_rd   = (!exp_err && op == 2'b00) ? 1 : 0;
        exp_edges = exp_err ? 1 : (op == 2'b01) ? 2 : (op == 2'b00) ? 2 + int'(RdLat)
                                                                 : 1 + int'(NUM_REGS);
        wr0   = wr_total;
        rd0   = rd_total;
        hits0 = wr_hits;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        edges = 0;
        while (cmd_ready !== 1'b1 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ":cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = 16'hDEAD;
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ":latency"}, 32'(edges), 32'(exp_edges));
        check({tag, ":rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, ":busy_resp"}, 32'(busy), 32'd1);
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ":hold_data"}, 32'(rsp_data), 32'(held));
            check({tag, ":hold_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ":rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ":idle_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, ":wr_strobes"}, 32'(wr_total - wr0), 32'(exp_wr));
        check({tag, ":rd_strobes"}, 32'(rd_total - rd0), 32'(exp_rd));
        if (op == 2'b10) begin
            mask = '0;
            for (int i = 0; i < 16; i++) mask[i] = (wr_hits[i] - hits0[i]) == 1;
            check({tag, ":fill_addrs"}, 32'(mask), 32'((1 << NUM_REGS) - 1));
        end

        if (!exp_err && op == 2'b01) model_regs[addr] = data;
        if (op == 2'b10) begin
            for (int i = 0; i < int'(NUM_REGS); i++) model_regs[i] = data;
        end
    endtask

    initial begin
        int edges;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({reg_write_en, reg_read_en}), 32'd0);
        check("rst_addr_data", 32'({reg_addr, reg_data_in}), 32'd0);
        check("rst_rsp", 32'({rsp_data, rsp_err}), 32'd0);
        rst = 1'b0;
        #1;
        check("release_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("release_ready_high", 32'(cmd_ready), 32'd1);

        send(2'b10, 4'd0, 16'h0000, 0, "init_fill");

        // Write then read back.
        send(2'b01, 4'd3, 16'hAAAD, 0, "t1_wr");
        send(2'b00, 4'd3, 16'h0000, 0, "t1_rd");

        for (int i = 0; i < int'(NUM_REGS); i++) send(2'b01, 4'(i), 16'hAAAA + 16'(i), 0, "t2_wr");
        for (int i = 0; i < int'(NUM_REGS); i++) send(2'b00, 4'(i), 16'h0000, 0, "t2_rd");

        // Invalid addresses and reserved op.
        send(2'b00, 4'd15, 16'h0000, 0, "t3_rd15");
        send(2'b01, 4'd14, 16'h1234, 0, "t3_wr14");
        send(2'b11, 4'd2, 16'h7777, 1, "t3_rsvd");
        send(2'b00, 4'd13, 16'h0000, 0, "t3_rd13");

        send(2'b10, 4'd9, 16'h5A5A, 0, "t4_fill");
        send(2'b00, 4'd0, 16'h0000, 0, "t4_rd0");
        send(2'b00, 4'd13, 16'h0000, 0, "t4_rd13");

        // Back-pressure.
        send(2'b01, 4'd5, 16'hC0DE, 0, "t5_wr");
        send(2'b00, 4'd5, 16'h0000, 5, "t5_rd");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom),
                 int'($urandom_range(0, 3)), "rand");
        end

        // Reset in the middle of a FILL.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_addr  = 4'd0;
        cmd_data  = 16'h0F0F;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        edges = 0;
        while (!(reg_write_en === 1'b1 && reg_addr === 4'd6) && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("t6_reach_idx6", 32'(reg_addr), 32'd6);
        rst = 1'b1;
        #1;
        check("t6_strobes", 32'({reg_write_en, reg_read_en}), 32'd0);
        check("t6_addr_data", 32'({reg_addr, reg_data_in}), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 6; i++) model_regs[i] = 16'h0F0F;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_ready_after", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        send(2'b00, 4'd0, 16'h0000, 0, "t6_rd0");
        send(2'b00, 4'd6, 16'h0000, 0, "t6_rd6");

        check("never_both_strobes", 32'(both_hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
